// File: rtl/freq_step_sequencer.sv
// freq_step_sequencer
// Steps the select input of the ROM-controlled frequency divider through a small
// programmable table. Each entry holds a select code and a dwell time. The dwell
// time is counted in divided-clock rising edges. The select code only changes on
// a divided-clock rising edge, so the divider never sees a change mid-period.
//
// Ports:
//   clk         single clock; all logic runs on its rising edge
//   reset       synchronous, active-high reset
//   wr_en       write one table entry this cycle (only honoured while idle)
//   wr_addr     entry index to write
//   wr_sel      select code for the entry
//   wr_dwell    dwell in divided-clock rising edges (0 behaves as 1)
//   last_idx    index of the final entry, captured at start
//   loop_en     wrap to entry 0 after last_idx instead of finishing, captured at start
//   start       single-cycle request to begin a sweep
//   stop        request to abort a running sweep
//   div_clk_in  divider output, already synchronous to clk
//   f_select    select code driven to the divider
//   busy        high while a sweep is running
//   done        one-cycle pulse when a sweep ends (completed or aborted)
//   step_idx    table entry currently applied
//   step_pulse  one-cycle pulse each time a new entry is applied
module freq_step_sequencer #(
  parameter int DEPTH = 8,
  parameter int SEL_W = 5,
  parameter int DWELL_W = 8,
  parameter logic [SEL_W-1:0] IDLE_SEL = '0,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [IW-1:0]      last_idx,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  input  logic               div_clk_in,
  output logic [SEL_W-1:0]   f_select,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      step_idx,
  output logic               step_pulse
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_n;

  logic [SEL_W-1:0]   tbl_sel   [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  logic               div_prev;
  logic               div_edge;
  logic               tbl_we;

  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [IW-1:0]      last_q, last_n;
  logic               loop_q, loop_n;
  logic               abort_q, abort_n;

  logic [SEL_W-1:0]   f_select_n;
  logic               busy_n, done_n, step_pulse_n;
  logic [IW-1:0]      step_idx_n;

  logic               load;
  logic [IW-1:0]      load_idx;
  logic               finish;
  logic [IW-1:0]      next_idx;

  // div_prev resets high so a divider output that is already high when reset
  // releases is not mistaken for a rising edge.
  assign div_edge = div_clk_in & ~div_prev;

  // Table writes only while idle, and never in the cycle a sweep is launched,
  // so the entries in use by a sweep can never change underneath it.
  assign tbl_we = wr_en & (state == IDLE) & ~start;

  // The index is IW bits wide, so advancing past DEPTH-1 wraps to 0 on its own.
  assign next_idx = step_idx + IW'(1);

  // Select/dwell table. Reset restores every entry to the idle code with dwell 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_sel[i]   <= IDLE_SEL;
        tbl_dwell[i] <= DWELL_W'(1);
      end
    end else if (tbl_we) begin
      tbl_sel[wr_addr]   <= wr_sel;
      tbl_dwell[wr_addr] <= wr_dwell;
    end
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_prev   <= 1'b1;
      dwell_cnt  <= DWELL_W'(1);
      last_q     <= '0;
      loop_q     <= 1'b0;
      abort_q    <= 1'b0;
      f_select   <= IDLE_SEL;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_idx   <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      div_prev   <= div_clk_in;
      dwell_cnt  <= dwell_cnt_n;
      last_q     <= last_n;
      loop_q     <= loop_n;
      abort_q    <= abort_n;
      f_select   <= f_select_n;
      busy       <= busy_n;
      done       <= done_n;
      step_idx   <= step_idx_n;
      step_pulse <= step_pulse_n;
    end
  end

  // Next-state and output logic. Any entry change goes through the shared
  // "load" path at the bottom, so launch, advance and wrap all apply an entry
  // the same way.
  always_comb begin
    state_n      = state;
    dwell_cnt_n  = dwell_cnt;
    last_n       = last_q;
    loop_n       = loop_q;
    abort_n      = abort_q;
    f_select_n   = f_select;
    busy_n       = busy;
    step_idx_n   = step_idx;
    done_n       = 1'b0;
    step_pulse_n = 1'b0;
    load         = 1'b0;
    load_idx     = '0;
    finish       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          last_n   = last_idx;
          loop_n   = loop_en;
          abort_n  = 1'b0;
          busy_n   = 1'b1;
          state_n  = RUN;
          load     = 1'b1;
          load_idx = '0;
        end
      end

      RUN: begin
        if (stop) begin
          abort_n = 1'b1;
        end
        // A stop arriving with this edge counts as already pending. This makes
        // the sweep abort rather than take a step. On the final step, abort and
        // completion lead to the same result.
        if (div_edge) begin
          if (abort_q || stop) begin
            finish = 1'b1;
          end else if (dwell_cnt != DWELL_W'(1)) begin
            dwell_cnt_n = dwell_cnt - DWELL_W'(1);
          end else if (step_idx != last_q) begin
            load     = 1'b1;
            load_idx = next_idx;
          end else if (loop_q) begin
            load     = 1'b1;
            load_idx = '0;
          end else begin
            finish = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (load) begin
      step_idx_n   = load_idx;
      f_select_n   = tbl_sel[load_idx];
      dwell_cnt_n  = (tbl_dwell[load_idx] == '0) ? DWELL_W'(1) : tbl_dwell[load_idx];
      step_pulse_n = 1'b1;
    end

    if (finish) begin
      state_n    = IDLE;
      f_select_n = IDLE_SEL;
      busy_n     = 1'b0;
      done_n     = 1'b1;
      abort_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_step_sequencer.sv
// Self-checking testbench for freq_step_sequencer.
// A behavioural reference model predicts the outputs cycle by cycle. The model
// counts edges seen on the current entry up to its required dwell. Directed
// scenarios from the test plan are followed by a randomized stress phase.
module tb_freq_step_sequencer;

  localparam int DEPTH   = 8;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 8;
  localparam int IW      = 3;
  localparam int IDLE_SEL_VAL = 0;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [IW-1:0]      wr_addr;
  logic [SEL_W-1:0]   wr_sel;
  logic [DWELL_W-1:0] wr_dwell;
  logic [IW-1:0]      last_idx;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               div_clk_in;
  logic [SEL_W-1:0]   f_select;
  logic               busy;
  logic               done;
  logic [IW-1:0]      step_idx;
  logic               step_pulse;

  always #5 clk = ~clk;

  freq_step_sequencer #(
    .DEPTH(DEPTH),
    .SEL_W(SEL_W),
    .DWELL_W(DWELL_W),
    .IDLE_SEL(SEL_W'(IDLE_SEL_VAL))
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_sel(wr_sel),
    .wr_dwell(wr_dwell),
    .last_idx(last_idx),
    .loop_en(loop_en),
    .start(start),
    .stop(stop),
    .div_clk_in(div_clk_in),
    .f_select(f_select),
    .busy(busy),
    .done(done),
    .step_idx(step_idx),
    .step_pulse(step_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_sel   [DEPTH];
  int m_dwell [DEPTH];
  bit m_run, m_prev, m_loop, m_abort;
  int m_last, m_idx, m_seen;
  int exp_sel, exp_idx;
  bit exp_busy, exp_done, exp_pulse;

  // Observed DUT outputs and scenario bookkeeping
  int obs_sel, obs_idx;
  bit obs_busy, obs_done, obs_pulse;
  int obs_pulses = 0;
  int obs_dones  = 0;
  int obs_seq[$];
  int obs_idxq[$];

  // Divided-clock generator: 0 = hold, 1 = periodic, 2 = random
  int div_mode = 0;
  int div_half = 4;
  int div_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int needEdges(input int dwell);
    return (dwell == 0) ? 1 : dwell;
  endfunction

  task automatic modelApply(input int k);
    m_idx     = k;
    m_seen    = 0;
    exp_sel   = m_sel[k];
    exp_idx   = k;
    exp_pulse = 1'b1;
  endtask

  task automatic modelFinish();
    m_run    = 1'b0;
    m_abort  = 1'b0;
    exp_sel  = IDLE_SEL_VAL;
    exp_done = 1'b1;
  endtask

  // Advances the reference model by one clk rising edge using the current inputs
  task automatic modelUpdate();
    bit rise;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_sel[i]   = IDLE_SEL_VAL;
        m_dwell[i] = 1;
      end
      m_run = 1'b0; m_prev = 1'b1; m_abort = 1'b0; m_loop = 1'b0;
      m_last = 0; m_idx = 0; m_seen = 0;
      exp_sel = IDLE_SEL_VAL; exp_idx = 0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_pulse = 1'b0;
      return;
    end
    rise   = div_clk_in && !m_prev;
    m_prev = div_clk_in;
    exp_done  = 1'b0;
    exp_pulse = 1'b0;
    if (!m_run) begin
      if (start) begin
        m_last  = int'(last_idx);
        m_loop  = loop_en;
        m_abort = 1'b0;
        m_run   = 1'b1;
        modelApply(0);
      end else if (wr_en) begin
        m_sel[wr_addr]   = int'(wr_sel);
        m_dwell[wr_addr] = int'(wr_dwell);
      end
    end else begin
      if (stop) m_abort = 1'b1;
      if (rise) begin
        if (m_abort) begin
          modelFinish();
        end else begin
          m_seen++;
          if (m_seen < needEdges(m_dwell[m_idx])) begin
            // still dwelling on this entry
          end else if (m_idx != m_last) begin
            modelApply((m_idx + 1) % DEPTH);
          end else if (m_loop) begin
            modelApply(0);
          end else begin
            modelFinish();
          end
        end
      end
    end
    exp_busy = m_run;
  endtask

  // One clk cycle: model update on the edge, compare shortly after, new divider level at negedge
  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    #1;
    obs_sel   = int'(f_select);
    obs_idx   = int'(step_idx);
    obs_busy  = busy;
    obs_done  = done;
    obs_pulse = step_pulse;
    if (step_pulse === 1'b1) begin
      obs_pulses++;
      obs_seq.push_back(int'(f_select));
      obs_idxq.push_back(int'(step_idx));
    end
    if (done === 1'b1) obs_dones++;
    checkOutput("f_select", 32'(f_select), exp_sel);
    checkOutput("step_idx", 32'(step_idx), exp_idx);
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("step_pulse", 32'(step_pulse), 32'(exp_pulse));
    checkOutput("pulse_done_excl", 32'(step_pulse & done), 0);
    @(negedge clk);
    case (div_mode)
      1: begin
        div_cnt++;
        if (div_cnt >= div_half) begin
          div_cnt    = 0;
          div_clk_in = ~div_clk_in;
        end
      end
      2: div_clk_in = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic writeEntry(input int addr, input int sel, input int dwell);
    wr_en    = 1'b1;
    wr_addr  = IW'(addr);
    wr_sel   = SEL_W'(sel);
    wr_dwell = DWELL_W'(dwell);
    applyStimulus();
    wr_en    = 1'b0;
  endtask

  task automatic startSweep(input int last, input bit loop);
    last_idx = IW'(last);
    loop_en  = loop;
    start    = 1'b1;
    applyStimulus();
    start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!obs_done && n < budget) begin
      applyStimulus();
      n++;
    end
    if (!obs_done) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic clearRecords();
    obs_seq.delete();
    obs_idxq.delete();
  endtask

  int p0, d0;
  int exp_basic[3] = '{3, 7, 12};

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_dwell = '0;
    last_idx = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; div_clk_in = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_sel", 32'(f_select), IDLE_SEL_VAL);
    checkOutput("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    applyStimulus();

    // Basic sweep
    writeEntry(0, 3, 2);
    writeEntry(1, 7, 1);
    writeEntry(2, 12, 3);
    div_mode = 1; div_half = 4; div_cnt = 0;
    clearRecords(); p0 = obs_pulses; d0 = obs_dones;
    startSweep(2, 1'b0);
    waitDone("basic", 200);
    checkOutput("basic_pulses", obs_pulses - p0, 3);
    checkOutput("basic_dones", obs_dones - d0, 1);
    for (int i = 0; i < 3; i++)
      if (i < obs_seq.size()) checkOutput("basic_seq", obs_seq[i], exp_basic[i]);
    applyStimulus();
    checkOutput("basic_busy_after", 32'(obs_busy), 0);
    checkOutput("basic_sel_after", obs_sel, IDLE_SEL_VAL);

    // Dwell zero behaves as one edge
    writeEntry(0, 5, 0);
    clearRecords(); p0 = obs_pulses; d0 = obs_dones;
    startSweep(0, 1'b0);
    waitDone("dwell0", 40);
    checkOutput("dwell0_pulses", obs_pulses - p0, 1);
    checkOutput("dwell0_dones", obs_dones - d0, 1);
    if (obs_seq.size() > 0) checkOutput("dwell0_sel", obs_seq[0], 5);

    // Loop, start-while-busy, then abort
    writeEntry(0, 4, 1);
    writeEntry(1, 9, 1);
    div_half = 2;
    clearRecords(); d0 = obs_dones;
    startSweep(1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus();
    start = 1'b1; applyStimulus(); start = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("loop_count_ok", 32'(obs_idxq.size() >= 6), 1);
    for (int i = 0; i < obs_idxq.size(); i++) checkOutput("loop_idx_seq", obs_idxq[i], i % 2);
    checkOutput("loop_no_done", obs_dones - d0, 0);
    stop = 1'b1; applyStimulus(); stop = 1'b0;
    waitDone("abort", 40);
    checkOutput("abort_dones", obs_dones - d0, 1);
    checkOutput("abort_sel", obs_sel, IDLE_SEL_VAL);

    // Write protection while running
    startSweep(1, 1'b0);
    applyStimulus();
    writeEntry(0, 31, 5);
    waitDone("wp_first", 60);
    startSweep(0, 1'b0);
    checkOutput("wp_sel", obs_sel, 4);
    waitDone("wp_second", 40);

    // Reset mid-sweep
    writeEntry(0, 3, 2);
    writeEntry(1, 7, 1);
    writeEntry(2, 12, 3);
    startSweep(2, 1'b0);
    for (int n = 0; n < 100 && obs_idx != 1; n++) applyStimulus();
    checkOutput("rst_reached_entry1", obs_idx, 1);
    d0 = obs_dones;
    reset = 1'b1; applyStimulus(); reset = 1'b0;
    checkOutput("rst_sel", obs_sel, IDLE_SEL_VAL);
    checkOutput("rst_busy", 32'(obs_busy), 0);
    checkOutput("rst_idx", obs_idx, 0);
    checkOutput("rst_pulse", 32'(obs_pulse), 0);
    checkOutput("rst_no_done", obs_dones - d0, 0);
    startSweep(0, 1'b0);
    checkOutput("rst_default_sel", obs_sel, IDLE_SEL_VAL);
    waitDone("rst_default", 40);

    // Edge filtering: divider high through reset release
    div_mode = 0; div_clk_in = 1'b1;
    reset = 1'b1; applyStimulus(); applyStimulus(); reset = 1'b0;
    writeEntry(0, 6, 1);
    startSweep(0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("filter_busy_high", 32'(obs_busy), 1);
    div_clk_in = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("filter_busy_low", 32'(obs_busy), 1);
    div_clk_in = 1'b1;
    applyStimulus();
    checkOutput("filter_done", 32'(obs_done), 1);

    // Randomized stress against the model
    div_mode = 2;
    for (int iter = 0; iter < 40; iter++) begin
      for (int c = 0; c < 120; c++) begin
        start    = ($urandom_range(0, 19) == 0);
        stop     = ($urandom_range(0, 39) == 0);
        wr_en    = ($urandom_range(0, 3) == 0);
        wr_addr  = IW'($urandom_range(0, DEPTH - 1));
        wr_sel   = SEL_W'($urandom_range(0, 31));
        wr_dwell = DWELL_W'($urandom_range(0, 3));
        last_idx = IW'($urandom_range(0, DEPTH - 1));
        loop_en  = 1'($urandom_range(0, 1));
        reset    = ($urandom_range(0, 299) == 0);
        applyStimulus();
      end
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0; reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_step_sequencer.md
# freq_step_sequencer

Programmable frequency-step scheduler for the ROM-controlled frequency divider. It holds a small table of divider select codes, each with a dwell time. On `start` it drives the divider's 5-bit select input through the table in order, dwelling on each code for a programmed number of divided-clock rising edges. Select changes happen only on a divided-clock rising edge, so the divider output is never glitched mid-period. It sits beside the divider in the top level and replaces the static select pins when a sweep is running.

## Interface
- `DEPTH`, 8: table entries; power of two; index width `IW` = log2(DEPTH).
- `SEL_W`, 5: width of the divider select code.
- `DWELL_W`, 8: width of the dwell count.
- `IDLE_SEL`, 0: select code driven whenever the block is not running.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write one table entry this cycle.
- `wr_addr`  in  IW  entry index to write.
- `wr_sel`  in  SEL_W  select code for the entry.
- `wr_dwell`  in  DWELL_W  dwell in divided-clock rising edges; 0 is treated as 1.
- `last_idx`  in  IW  index of the final entry; sampled at start.
- `loop_en`  in  1  wrap to entry 0 after `last_idx` instead of finishing; sampled at start.
- `start`  in  1  single-cycle request to begin a sweep.
- `stop`  in  1  request to abort a running sweep.
- `div_clk_in`  in  1  divider output, already in the `clk` domain.
- `f_select`  out  SEL_W  select code to the divider.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep ends (completed or aborted).
- `step_idx`  out  IW  entry currently applied.
- `step_pulse`  out  1  one-cycle pulse each time a new entry is applied.

## Operation
- States: IDLE and RUN.
- Reset values:
  - `f_select`=IDLE_SEL, `busy`=0, `done`=0, `step_idx`=0, `step_pulse`=0.
  - State is IDLE.
  - All table entries are {IDLE_SEL, dwell 1}.
  - Edge-detect register `div_prev`=1, so a high input right after reset is not seen as an edge.
- Edge detect: `div_edge` = `div_clk_in` & ~`div_prev`. `div_prev` samples `div_clk_in` every cycle in every state.
- Table writes:
  - Accepted only in IDLE and only when `start` is low that cycle.
  - Ignored in RUN, and ignored in the same cycle a start is accepted.
- IDLE → RUN on `start`:
  - Latch `last_idx` and `loop_en`.
  - `step_idx`←0, `f_select`←table[0].sel.
  - Dwell counter ← max(table[0].dwell, 1).
  - `busy`←1, `step_pulse`←1.
- RUN, on each `div_edge`, the counter decrements. When an edge arrives with counter==1:
  - If `step_idx` != latched last index: advance to `step_idx`+1, load its sel and dwell, pulse `step_pulse`.
  - Else if loop is latched on: wrap to entry 0, load it, pulse `step_pulse`.
  - Else go to IDLE: `f_select`←IDLE_SEL, `busy`←0, `done`←1.
- `stop` in RUN:
  - Sets a sticky abort flag.
  - On the next `div_edge`, go to IDLE with the same outputs as completion (`done` pulses once).
  - `stop` in IDLE is ignored.
  - The abort flag clears on entry to IDLE.
- `start` in RUN is ignored.
- The index counter is IW bits wide. It wraps naturally when `last_idx`=DEPTH-1 and loop is on.
- Synchronous `reset` in RUN returns every output to its reset value on the next edge. No `done` pulse is produced.

## Timing
- `start` sampled high in cycle T: in T+1, `busy`=1, `f_select`=table[0].sel, `step_pulse`=1.
- `div_edge` true in cycle E: the counter, `f_select`, `step_idx`, `step_pulse` and `done` changes are all visible in E+1.
- Entry k is applied for exactly max(dwell_k, 1) divided-clock rising edges, counted after the entry is applied.
- `step_pulse` and `done` are exactly one cycle wide. They never assert in the same cycle.
- Completion and abort paths:
  - Completion without loop: the last edge is seen in cycle E; `busy` falls and `done` rises in E+1.
  - `stop` and the final-step edge in the same cycle: treated as completion; a single `done` pulse.
  - `stop` asserted in the same cycle as a non-final step edge: the step is not taken; the sweep aborts on that edge.
- The earliest new `start` is accepted in the cycle `done` is high.

## Test plan
- Basic sweep:
  - Stimulus: write {3,2},{7,1},{12,3}; `last_idx`=2, loop off; start; `div_clk_in` toggles every 4 clk.
  - Response: `f_select` = 3 for 2 edges, then 7 for 1 edge, then 12 for 3 edges, then 0. Three `step_pulse`s, one `done`, `busy` low after.
- Dwell zero: entry 0 = {5,0}, `last_idx`=0.
  - Response: `f_select`=5 for exactly one edge, then `done`.
- Loop and abort:
  - Stimulus: `last_idx`=1, loop on, entries {4,1},{9,1}.
  - Response: `step_idx` sequence 0,1,0,1,…
  - Raise `stop` mid-dwell: the block returns to IDLE on the next edge, `f_select`=0, one `done`.
- Write protection: during RUN, write {31,5} to entry 0.
  - Response: no effect. After `done`, a restart still shows the old entry 0.
- Reset mid-sweep: assert `reset` during entry 1.
  - Response: next cycle all outputs are 0 and `f_select`=IDLE_SEL, with no `done`.
  - Table is back to defaults: a start with `last_idx`=0 gives `f_select`=0 for 1 edge.
- Edge filtering:
  - Hold `div_clk_in` high through reset release: no dwell decrement until the first low→high transition.
  - `start` while busy: no change in `step_idx` or counter.
